// File: rtl/uart_peripheral.sv
// Memory-mapped UART: 4-entry TX FIFO, single-byte RX holding register,
// programmable bit period and a level interrupt, all on one clock.
module uart_peripheral #(
    parameter logic [31:0] base_address = 32'h40E0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] data_bus_read,
    input  logic [31:0] data_bus_write,
    input  logic        data_bus_select,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        uart_irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

    logic [31:0] offset;
    logic        bus_rd, bus_wr, sel_data, sel_status, sel_baud, sel_ctrl;

    assign offset     = data_bus_addr - base_address;
    assign bus_rd     = data_bus_select && (data_bus_mode == 2'b01);
    assign bus_wr     = data_bus_select && (data_bus_mode == 2'b10);
    assign sel_data   = (offset == 32'h0);
    assign sel_status = (offset == 32'h4);
    assign sel_baud   = (offset == 32'h8);
    assign sel_ctrl   = (offset == 32'hC);

    logic [15:0] baud_q, baud_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [7:0]  rx_hold_q, rx_hold_d;
    logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
    logic        frame_err_q, frame_err_d, tx_ovf_q, tx_ovf_d, irq_q, irq_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  fifo_mem [4];
    logic        rx_meta_q, rx_sync_q, rx_prev_q;

    uart_state_e tx_state_q, rx_state_q;
    logic [15:0] tx_cnt_q, rx_cnt_q;
    logic [2:0]  tx_bit_q, rx_bit_q;
    logic [7:0]  tx_shift_q, rx_shift_q;
    logic        tx_q;

    logic        tx_busy, tx_full, tx_empty, tx_pop, push, push_ok, data_rd;
    logic        rx_done, rx_ferr;
    logic [16:0] baud_p1;
    logic [15:0] rx_half_m1;

    assign tx_busy  = (tx_state_q != ST_IDLE);
    assign tx_full  = (count_q == 3'd4);
    assign tx_empty = (count_q == 3'd0);
    // A pop happens when the line is free: from IDLE, or at the last clock of STOP.
    assign tx_pop   = !tx_empty &&
                      ((tx_state_q == ST_IDLE) || (tx_state_q == ST_STOP && tx_cnt_q == 16'd0));
    assign push     = bus_wr && sel_data;
    assign push_ok  = push && (!tx_full || tx_pop);
    assign data_rd  = bus_rd && sel_data;

    assign rx_done  = (rx_state_q == ST_STOP) && (rx_cnt_q == 16'd0) && rx_sync_q;
    assign rx_ferr  = (rx_state_q == ST_STOP) && (rx_cnt_q == 16'd0) && !rx_sync_q;
    assign baud_p1  = {1'b0, baud_q} + 17'd1;
    assign rx_half_m1 = (baud_p1[16:1] == 16'd0) ? 16'd0 : baud_p1[16:1] - 16'd1;

    logic unused_bits;
    assign unused_bits = ^{data_bus_write[31:16], data_bus_write[2], baud_p1[0]};

    always_comb begin
        data_bus_read = '0;
        if (bus_rd) begin
            if (sel_data)   data_bus_read = {24'b0, rx_hold_q};
            if (sel_status) data_bus_read = {26'b0, frame_err_q, rx_ovr_q, tx_ovf_q,
                                             tx_busy, tx_full, rx_valid_q};
            if (sel_baud)   data_bus_read = {16'b0, baud_q};
            if (sel_ctrl)   data_bus_read = {30'b0, ctrl_q};
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        baud_d      = baud_q;
        ctrl_d      = ctrl_q;
        rx_hold_d   = rx_hold_q;
        rx_ovr_d    = rx_ovr_q;
        frame_err_d = frame_err_q;
        tx_ovf_d    = tx_ovf_q;
        wr_ptr_d    = push_ok ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d    = tx_pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d     = count_q;
        case ({push_ok, tx_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (bus_wr && sel_baud) baud_d = data_bus_write[15:0];
        if (bus_wr && sel_ctrl) ctrl_d = data_bus_write[1:0];
        if (bus_wr && sel_status) begin
            if (data_bus_write[5]) frame_err_d = 1'b0;
            if (data_bus_write[4]) rx_ovr_d    = 1'b0;
            if (data_bus_write[3]) tx_ovf_d    = 1'b0;
        end
        // Hardware set events take priority over a same-cycle software clear.
        rx_valid_d = rx_valid_q && !data_rd;
        if (rx_done) begin
            rx_hold_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !data_rd) rx_ovr_d = 1'b1;
        end
        if (rx_ferr) frame_err_d = 1'b1;
        if (push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
        irq_d = (ctrl_q[0] && rx_valid_q) || (ctrl_q[1] && tx_empty && !tx_busy);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            baud_q      <= 16'd433;
            ctrl_q      <= 2'b00;
            rx_hold_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ovf_q    <= 1'b0;
            irq_q       <= 1'b0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
        end else begin
            baud_q      <= baud_d;
            ctrl_q      <= ctrl_d;
            rx_hold_q   <= rx_hold_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
            tx_ovf_q    <= tx_ovf_d;
            irq_q       <= irq_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= data_bus_write[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                ST_IDLE: if (tx_pop) begin
                    tx_state_q <= ST_START;
                    tx_q       <= 1'b0;
                    tx_cnt_q   <= baud_q;
                    tx_shift_q <= fifo_mem[rd_ptr_q];
                end
                ST_START: if (tx_cnt_q == 16'd0) begin
                    tx_state_q <= ST_DATA;
                    tx_q       <= tx_shift_q[0];
                    tx_cnt_q   <= baud_q;
                    tx_bit_q   <= 3'd0;
                end else tx_cnt_q <= tx_cnt_q - 16'd1;
                ST_DATA: if (tx_cnt_q == 16'd0) begin
                    tx_cnt_q <= baud_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= ST_STOP;
                        tx_q       <= 1'b1;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 3'd1;
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_q       <= tx_shift_q[1];
                    end
                end else tx_cnt_q <= tx_cnt_q - 16'd1;
                ST_STOP: if (tx_cnt_q == 16'd0) begin
                    if (tx_pop) begin
                        tx_state_q <= ST_START;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= baud_q;
                        tx_shift_q <= fifo_mem[rd_ptr_q];
                    end else tx_state_q <= ST_IDLE;
                end else tx_cnt_q <= tx_cnt_q - 16'd1;
                default: tx_state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            case (rx_state_q)
                ST_IDLE: if (rx_prev_q && !rx_sync_q) begin
                    rx_state_q <= ST_START;
                    rx_cnt_q   <= rx_half_m1;
                end
                // Start bit re-checked mid-bit; a high level here was a glitch.
                ST_START: if (rx_cnt_q == 16'd0) begin
                    rx_state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
                    rx_cnt_q   <= baud_q;
                    rx_bit_q   <= 3'd0;
                end else rx_cnt_q <= rx_cnt_q - 16'd1;
                ST_DATA: if (rx_cnt_q == 16'd0) begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_q   <= baud_q;
                    rx_bit_q   <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_q <= ST_STOP;
                end else rx_cnt_q <= rx_cnt_q - 16'd1;
                ST_STOP: if (rx_cnt_q == 16'd0) rx_state_q <= ST_IDLE;
                         else rx_cnt_q <= rx_cnt_q - 16'd1;
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    assign uart_tx  = tx_q;
    assign uart_irq = irq_q;

endmodule

// File: doc/uart_peripheral.md
UART_PERIPHERAL -- requirements
Module: uart_peripheral

Interface
REQ-001 SHALL have parameter base_address, default 32'h40E0, word-aligned base of the 16-byte register window.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 SHALL have port data_bus_read  output  32  read data for the selected register.
REQ-005 SHALL have port data_bus_write  input  32  write data.
REQ-006 SHALL have port data_bus_select  input  1  slave select from bus_arbiter.
REQ-007 SHALL have port data_bus_addr  input  32  byte address.
REQ-008 SHALL have port data_bus_mode  input  2  2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 reserved (treated as idle).
REQ-009 SHALL have port uart_rx  input  1  serial input, idle high, asynchronous.
REQ-010 SHALL have port uart_tx  output  1  serial output, idle high.
REQ-011 SHALL have port uart_irq  output  1  level interrupt request to the ICU.

Function
REQ-012 SHALL decode offset = data_bus_addr - base_address: 0x0 DATA, 0x4 STATUS, 0x8 BAUD, 0xC CTRL; other offsets read 0 and ignore writes.
REQ-013 SHALL drive data_bus_read combinationally; it SHALL be 0 when data_bus_select is low or mode is not read.
REQ-014 SHALL act on a write only when data_bus_select=1 and mode=2'b10, for exactly one cycle per asserted cycle.
REQ-015 Write DATA: SHALL push data_bus_write[7:0] into a 4-entry TX FIFO; push when full SHALL be dropped and set STATUS.tx_ovf.
REQ-016 Read DATA: SHALL return {24'b0, rx_hold}; the selected read cycle SHALL clear rx_valid at the clock edge.
REQ-017 STATUS SHALL read {26'b0, frame_err, rx_ovr, tx_ovf, tx_busy, tx_full, rx_valid} (bits 5..0).
REQ-018 Write STATUS: bits 5..3 SHALL be write-1-to-clear; other bits read-only.
REQ-019 BAUD[15:0]: bit period SHALL be BAUD+1 clocks; BAUD writes take effect at the next bit boundary; bits 31:16 read 0.
REQ-020 CTRL bit0 rx_ie, bit1 tx_ie; uart_irq SHALL equal (rx_ie & rx_valid) | (tx_ie & tx_fifo_empty & ~tx_busy), registered (1-cycle latency).
REQ-021 TX FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty (pop same cycle); each state lasts one bit period; DATA sends 8 bits LSB first; STOP->START directly if FIFO non-empty, else IDLE.
REQ-022 tx_busy SHALL be 1 in any state other than IDLE.
REQ-023 uart_rx SHALL pass a 2-flop synchronizer before use.
REQ-024 RX FSM states IDLE, START, DATA, STOP; IDLE->START on synchronized 1->0; sample at (BAUD+1)/2 clocks (integer division); if sample high, return to IDLE (glitch); then sample every BAUD+1 clocks for 8 data bits and stop bit.
REQ-025 Stop bit low: SHALL set frame_err and discard the byte.
REQ-026 Valid byte with rx_valid already 1: SHALL overwrite rx_hold and set rx_ovr.
REQ-027 Byte completion coinciding with a DATA read: read returns old byte, rx_valid remains 1 with new byte, rx_ovr not set.
REQ-028 FIFO push and pop in the same cycle when full SHALL both succeed with no overflow; when empty the push SHALL be held and popped next cycle.

Reset
REQ-029 On reset low: uart_tx=1, uart_irq=0, both FSMs IDLE, FIFO empty, rx_hold=0, all STATUS flags 0, CTRL=0, BAUD=16'd433.
REQ-030 Reset asserted mid-frame SHALL abort the frame; uart_tx=1 on the first edge with reset low.

Verification
REQ-031 BAUD=3, write DATA 0xA5 -> uart_tx low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, high 4 clks; tx_busy high throughout.
REQ-032 Write five bytes 0x01..0x05 back-to-back while idle -> first pops immediately, 0x01..0x05 all sent back-to-back (FIFO refilled as drained), tx_ovf=0; a sixth write while FIFO holds 4 -> tx_ovf=1.
REQ-033 BAUD=3, drive 0x3C frame on uart_rx -> rx_valid=1, DATA reads 0x3C, rx_valid=0 after read; with rx_ie=1, uart_irq rises one cycle after rx_valid.
REQ-034 Two frames 0x11, 0x22 with no read -> DATA=0x22, rx_ovr=1; write STATUS 0x10 -> rx_ovr=0.
REQ-035 Frame with stop bit 0 -> frame_err=1, rx_valid unchanged; 1-clock low glitch on uart_rx -> no state change.
REQ-036 Reset low during TX DATA bit 3 -> uart_tx=1, tx_busy=0, FIFO empty, BAUD=433 next cycle.
